// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch front-end.
//   XLEN          default address/data width
//   INSTR_BYTES   fetch stride in bytes
//   fetch_entry_t {pc, instr} pair handed to decode
//   cnt_width()   width of a counter able to hold 0..depth
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with registered storage.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, wdata write request and data (ignored when full)
//   pop         read request (ignored when empty); rdata shows the head
//   flush       empties the FIFO; has priority over push/pop
//   full, empty status flags
//   count       number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-2 depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch front-end with up to MAX_OUTSTANDING
// in-order memory requests and a DEPTH-entry prefetch FIFO feeding decode.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   proc_req, Add          fetch request and address to memory
//   mem_ready              memory accepts the request this cycle
//   valid, Rdata           in-order memory response
//   instr_o, instr_pc_o    instruction and its PC to decode
//   instr_valid_o          decode output valid
//   instr_ready_i          decode consumes this cycle
//   redirect_i, redirect_pc_i  flush and restart fetch at a new PC
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the prefetch FIFO is empty.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = fetch_pkg::XLEN,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            proc_req,
    input  logic            mem_ready,
    output logic [XLEN-1:0] Add,
    input  logic            valid,
    input  logic [XLEN-1:0] Rdata,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam int unsigned OUT_W = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [XLEN-1:0]   fetch_pc;
    logic [OUT_W-1:0]  discard;

    // req_pc tracker: its occupancy is the outstanding-request count.
    logic [XLEN-1:0]   rq_rdata;
    logic              rq_full;
    logic              rq_empty;
    logic [OUT_W-1:0]  outstanding;

    logic [2*XLEN-1:0] pf_rdata;
    logic              pf_full;
    logic              pf_empty;
    logic [CNT_W-1:0]  pf_count;
    logic              pf_push;
    logic              pf_pop;

    logic              accept;
    logic              resp_ok;
    logic              resp_keep;
    logic [CNT_W:0]    credit_sum;
    logic              out_valid;
    logic [2*XLEN-1:0] out_entry;

    assign credit_sum = (CNT_W+1)'(outstanding) + (CNT_W+1)'(pf_count);

    // Credits cover both in-flight words and buffered words, so a returning
    // response always finds room in the prefetch FIFO.
    assign proc_req = !reset && !redirect_i && !rq_full && !pf_full
                      && (credit_sum < (CNT_W+1)'(DEPTH));
    assign Add      = fetch_pc;
    assign accept   = proc_req && mem_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok   = valid && !rq_empty;
    assign resp_keep = resp_ok && !redirect_i && (discard == '0);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = resp_keep && pf_empty;
    assign out_valid = !pf_empty || bypass;
    assign out_entry = pf_empty ? {rq_rdata, Rdata} : pf_rdata;
    assign pf_push   = resp_keep && !(bypass && instr_ready_i);
`else
    assign out_valid = !pf_empty;
    assign out_entry = pf_rdata;
    assign pf_push   = resp_keep;
`endif

    assign instr_valid_o = !reset && out_valid;
    assign instr_pc_o    = instr_valid_o ? out_entry[2*XLEN-1:XLEN] : '0;
    assign instr_o       = instr_valid_o ? out_entry[XLEN-1:0] : '0;

    // Only FIFO-resident words are popped; a bypassed word never entered it.
    assign pf_pop = instr_valid_o && instr_ready_i && !pf_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect_i) begin
            // Every request still in flight after this cycle returns stale.
            fetch_pc <= redirect_pc_i;
            discard  <= outstanding - OUT_W'(resp_ok);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
            if (resp_ok && (discard != '0)) begin
                discard <= discard - OUT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_req_pc (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (resp_ok),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (rq_rdata),
        .full  (rq_full),
        .empty (rq_empty),
        .count (outstanding)
    );

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_prefetch (
        .clk   (clk),
        .reset (reset),
        .push  (pf_push),
        .pop   (pf_pop),
        .flush (redirect_i),
        .wdata ({rq_rdata, Rdata}),
        .rdata (pf_rdata),
        .full  (pf_full),
        .empty (pf_empty),
        .count (pf_count)
    );

    resp_protocol: assert property (@(posedge clk) disable iff (reset)
        !(valid && rq_empty));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        proc_req;
    logic        mem_ready;
    logic [31:0] Add;
    logic        valid;
    logic [31:0] Rdata;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int           checks   = 0;
    int           failures = 0;
    int           acc_cnt  = 0;
    logic         resp_en;
    fetch_entry_t exp_q[$];
    logic [31:0]  pend[$];

    fetch_prefetch_unit #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .proc_req      (proc_req),
        .mem_ready     (mem_ready),
        .Add           (Add),
        .valid         (valid),
        .Rdata         (Rdata),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h00A0_0093;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] a);
        fetch_entry_t e;
        e.pc    = a;
        e.instr = mem_data(a);
        exp_q.push_back(e);
    endtask

    // Hold mem_ready until exactly n more requests have been accepted.
    task automatic accept_n(input int n);
        int target;
        int start;
        start     = acc_cnt;
        target    = acc_cnt + n;
        mem_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc_cnt >= target) begin
                mem_ready = 1'b0;
                return;
            end
        end
        mem_ready = 1'b0;
        checks++;
        failures++;
        $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_cnt - start, n);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        @(negedge clk);
        check("redirect_cycle_proc_req", {31'b0, proc_req}, 32'd0);
        step();
        redirect_i = 1'b0;
    endtask

    // Memory model: answers each accepted request one cycle later, in order.
    initial begin : memory
        logic [31:0] a;
        valid = 1'b0;
        Rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                pend.delete();
                valid = 1'b0;
                Rdata = '0;
            end else if (resp_en && pend.size() > 0) begin
                a     = pend.pop_front();
                valid = 1'b1;
                Rdata = mem_data(a);
            end else begin
                valid = 1'b0;
                Rdata = '0;
            end
            @(negedge clk);
            if (!reset && proc_req && mem_ready) begin
                pend.push_back(Add);
                acc_cnt++;
            end
        end
    end

    // Scoreboard monitor: compares every consumed instruction to the queue head.
    initial begin : monitor
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid_o && instr_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc_o, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc_o, e.pc);
                    check("instr", instr_o, e.instr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int vcnt;
        int first;
        int last;
        int base;
        int target;

        reset         = 1'b1;
        mem_ready     = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        resp_en       = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_proc_req", {31'b0, proc_req}, 32'd0);
        check("reset_instr_valid", {31'b0, instr_valid_o}, 32'd0);
        check("reset_instr", instr_o, 32'd0);
        check("reset_instr_pc", instr_pc_o, 32'd0);
        check("reset_add", Add, 32'h0000_0000);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("first_proc_req", {31'b0, proc_req}, 32'd1);
        check("first_add", Add, 32'h0000_0000);
        check("idle_instr_valid", {31'b0, instr_valid_o}, 32'd0);

        // Streaming: 16 words, one per cycle once filled
        step();
        for (int i = 0; i < 16; i++) expect_pc(32'(4 * i));
        instr_ready_i = 1'b1;
        target        = acc_cnt + 16;
        mem_ready     = 1'b1;
        vcnt  = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                vcnt++;
                if (first < 0) first = c;
                last = c;
            end
            step();
            if (acc_cnt >= target) mem_ready = 1'b0;
        end
        check("stream_count", 32'(vcnt), 32'd16);
        check("stream_gapless", 32'(last - first + 1), 32'd16);
        drain("stream_drain");

        // Decode stalled: exactly DEPTH words in flight/buffered
        instr_ready_i = 1'b0;
        base          = acc_cnt;
        mem_ready     = 1'b1;
        for (int i = 0; i < 5; i++) expect_pc(32'h40 + 32'(4 * i));
        repeat (8) step();
        @(negedge clk);
        check("stall_accepts", 32'(acc_cnt - base), 32'd4);
        check("stall_proc_req", {31'b0, proc_req}, 32'd0);
        check("stall_head_valid", {31'b0, instr_valid_o}, 32'd1);
        check("stall_head_pc", instr_pc_o, 32'h40);
        step();
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("pop_cycle_proc_req", {31'b0, proc_req}, 32'd0);
        step();
        instr_ready_i = 1'b0;
        @(negedge clk);
        check("resume_proc_req", {31'b0, proc_req}, 32'd1);
        check("resume_add", Add, 32'h50);
        step();
        mem_ready     = 1'b0;
        instr_ready_i = 1'b1;
        drain("stall_drain");

        // Redirect with two requests in flight
        do_redirect(32'h10);
        @(negedge clk);
        check("redir_idle_proc_req", {31'b0, proc_req}, 32'd1);
        check("redir_idle_add", Add, 32'h10);
        step();
        resp_en = 1'b0;
        accept_n(2);
        @(negedge clk);
        check("inflight_proc_req", {31'b0, proc_req}, 32'd0);
        step();
        do_redirect(32'h200);
        resp_en = 1'b1;
        expect_pc(32'h200);
        expect_pc(32'h204);
        @(negedge clk);
        check("redir_add", Add, 32'h200);
        check("redir_instr_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        accept_n(2);
        drain("redirect_drain");

        // Redirect coinciding with a response and a decode pop
        step();
        instr_ready_i = 1'b0;
        accept_n(2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("rc_valid", {31'b0, instr_valid_o}, 32'd1);
        check("rc_head_pc", instr_pc_o, 32'h208);
        check("rc_proc_req", {31'b0, proc_req}, 32'd0);
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("rc_after_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rc_after_add", Add, 32'h300);
        check("rc_after_proc_req", {31'b0, proc_req}, 32'd1);
        expect_pc(32'h300);
        step();
        accept_n(1);
        drain("rc_drain");

        // Address wrap
        step();
        do_redirect(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        accept_n(3);
        @(negedge clk);
        check("wrap_add", Add, 32'h0000_0004);
        step();
        drain("wrap_drain");

        // Response latency into an empty FIFO
        step();
        do_redirect(32'h40);
        expect_pc(32'h40);
        accept_n(1);
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        check("byp_valid", {31'b0, instr_valid_o}, 32'd1);
        check("byp_instr", instr_o, 32'h00A0_0093);
        check("byp_pc", instr_pc_o, 32'h40);
        step();
        @(negedge clk);
        check("byp_fifo_empty", {31'b0, instr_valid_o}, 32'd0);
`else
        check("lat_resp_cycle_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        @(negedge clk);
        check("lat_valid", {31'b0, instr_valid_o}, 32'd1);
        check("lat_instr", instr_o, 32'h00A0_0093);
        check("lat_pc", instr_pc_o, 32'h40);
`endif
        step();
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
